// File: rtl/fp_compare_pipe.sv
`timescale 1ns/1ps
// fp_compare_pipe
//   Pipelined comparator for FloPoCo-format floating-point operands.
//   The comparison is resolved combinationally at the input from the
//   classification, sign and magnitude fields (no subtractor). The result
//   then travels with its tag through LAT register stages that all advance
//   together.
//
//   Optional feature: define FPCMP_NAN_COUNT_EN to build the saturating
//   16-bit unordered-compare counter. Without it nan_count is tied to 0
//   and nan_clr is ignored.
//
//   Ports:
//     clk, rst            clock (rising edge), async active-high reset
//     in_valid/in_ready   input handshake; in_ready = advance
//     in_a, in_b          operands {exc[1:0], sign, exponent, fraction}
//     in_op               000 EQ, 001 NE, 010 LT, 011 LE, 100 GT, 101 GE
//     in_tag              opaque tag carried with the operand pair
//     out_valid/out_ready output handshake
//     out_result          (A op B); 0 for reserved ops
//     out_unord           at least one operand is NaN
//     out_tag             tag of the result
//     nan_clr, nan_count  counter clear / unordered-compare count
//
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   The whole pipeline advances when advance = !out_valid || out_ready;
//   while stalled every stage and output holds its value.
module fp_compare_pipe #(
    parameter int WE   = 11,
    parameter int WF   = 20,
    parameter int LAT  = 2,
    parameter int TAGW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WE+WF+2:0]      in_a,
    input  logic [WE+WF+2:0]      in_b,
    input  logic [2:0]            in_op,
    input  logic [TAGW-1:0]       in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_result,
    output logic                  out_unord,
    output logic [TAGW-1:0]       out_tag,
    input  logic                  nan_clr,
    output logic [15:0]           nan_count
);

    localparam int W  = WE + WF + 3;
    localparam int EF = WE + WF;

    // ---------------- operand decode ----------------
    logic [1:0]    w_exc_a, w_exc_b;
    logic          w_nan_a, w_nan_b;
    logic          w_neg_a, w_neg_b;
    logic [EF+1:0] w_mag_a, w_mag_b;
    logic          w_eq, w_lt, w_unord, w_res;
    logic          w_adv;

    assign w_exc_a = in_a[W-1 -: 2];
    assign w_exc_b = in_b[W-1 -: 2];
    assign w_nan_a = (w_exc_a == 2'b11);
    assign w_nan_b = (w_exc_b == 2'b11);

    // A zero is never negative, so +0 and -0 compare equal.
    assign w_neg_a = in_a[EF] && (w_exc_a != 2'b00);
    assign w_neg_b = in_b[EF] && (w_exc_b != 2'b00);

    // Magnitude key: the exc code already ranks zero < normal < inf, so it
    // forms the top bits; exponent/fraction only matter for normals.
    assign w_mag_a = {w_exc_a, (w_exc_a == 2'b01) ? in_a[EF-1:0] : {EF{1'b0}}};
    assign w_mag_b = {w_exc_b, (w_exc_b == 2'b01) ? in_b[EF-1:0] : {EF{1'b0}}};

    assign w_eq = (w_neg_a == w_neg_b) && (w_mag_a == w_mag_b);
    // Differing signs: the negative one is smaller. Both negative: larger
    // magnitude is smaller.
    assign w_lt = (w_neg_a != w_neg_b) ? w_neg_a :
                  (w_neg_a ? (w_mag_a > w_mag_b) : (w_mag_a < w_mag_b));
    assign w_unord = w_nan_a || w_nan_b;

    always_comb begin
        w_res = 1'b0;
        case (in_op)
            3'b000:  w_res = !w_unord && w_eq;
            3'b001:  w_res = w_unord || !w_eq;
            3'b010:  w_res = !w_unord && w_lt;
            3'b011:  w_res = !w_unord && (w_lt || w_eq);
            3'b100:  w_res = !w_unord && !w_lt && !w_eq;
            3'b101:  w_res = !w_unord && !w_lt;
            default: w_res = 1'b0;
        endcase
    end

    // ---------------- pipeline stages ----------------
    logic [LAT-1:0]  r_vld;
    logic [LAT-1:0]  r_res;
    logic [LAT-1:0]  r_unord;
    logic [TAGW-1:0] r_tag [LAT];

    assign w_adv    = !r_vld[LAT-1] || out_ready;
    assign in_ready = w_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= '0;
            r_res   <= '0;
            r_unord <= '0;
            for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
        end else if (w_adv) begin
            // Idle input still shifts in valid=0, so bubbles propagate.
            r_vld[0]   <= in_valid;
            r_res[0]   <= w_res;
            r_unord[0] <= w_unord;
            r_tag[0]   <= in_tag;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_res[i]   <= r_res[i-1];
                r_unord[i] <= r_unord[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

    assign out_valid  = r_vld[LAT-1];
    assign out_result = r_res[LAT-1];
    assign out_unord  = r_unord[LAT-1];
    assign out_tag    = r_tag[LAT-1];

    // ---------------- unordered-compare counter ----------------
`ifdef FPCMP_NAN_COUNT_EN
    logic [15:0] r_nan_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nan_count <= '0;
        end else if (nan_clr) begin
            r_nan_count <= '0;
        end else if (in_valid && w_adv && w_unord && (r_nan_count != 16'hFFFF)) begin
            r_nan_count <= r_nan_count + 16'd1;
        end
    end

    assign nan_count = r_nan_count;
`else
    logic w_unused_nan_clr;
    assign w_unused_nan_clr = nan_clr;
    assign nan_count        = 16'd0;
`endif

endmodule

// File: tb/tb_fp_compare_pipe.sv
`timescale 1ns/1ps
// Directed self-checking bench for fp_compare_pipe (WE=11, WF=20, LAT=2).
module tb_fp_compare_pipe;

    localparam logic [33:0] POS1 = 34'h13FF00000;
    localparam logic [33:0] POS2 = 34'h140000000;
    localparam logic [33:0] NEG1 = 34'h1BFF00000;
    localparam logic [33:0] NEG2 = 34'h1C0000000;
    localparam logic [33:0] PZER = 34'h000000000;
    localparam logic [33:0] NZER = 34'h080000000;
    localparam logic [33:0] PINF = 34'h200000000;
    localparam logic [33:0] NINF = 34'h280000000;
    localparam logic [33:0] QNAN = 34'h300000000;

    localparam logic [2:0] OP_EQ = 3'b000;
    localparam logic [2:0] OP_NE = 3'b001;
    localparam logic [2:0] OP_LT = 3'b010;
    localparam logic [2:0] OP_LE = 3'b011;
    localparam logic [2:0] OP_GT = 3'b100;
    localparam logic [2:0] OP_GE = 3'b101;
    localparam logic [2:0] OP_RS = 3'b110;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [33:0] in_a, in_b;
    logic [2:0]  in_op;
    logic [7:0]  in_tag;
    logic        out_valid, out_ready, out_result, out_unord;
    logic [7:0]  out_tag;
    logic        nan_clr;
    logic [15:0] nan_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_q[$];

    fp_compare_pipe #(.WE(11), .WF(20), .LAT(2), .TAGW(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_unord(out_unord), .out_tag(out_tag),
        .nan_clr(nan_clr), .nan_count(nan_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [33:0] a, input logic [33:0] b,
                          input logic [2:0] op, input logic [7:0] tag);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_tag   = tag;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if ({out_result, out_unord, out_tag} !== 10'd0) begin
            n_errors++; $display("FAIL reset_outputs: got res=%b unord=%b tag=%h want 0",
                                 out_result, out_unord, out_tag);
        end
        n_checks++;
        if (nan_count !== 16'd0) begin
            n_errors++; $display("FAIL reset_nan_count: got %h want 0", nan_count);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] ta [4];
        logic [33:0] tb [4];
        logic [2:0]  to [4];
        ta[0] = POS2; tb[0] = POS1; to[0] = OP_GE;
        ta[1] = POS1; tb[1] = POS1; to[1] = OP_GE;
        ta[2] = NEG1; tb[2] = POS1; to[2] = OP_LT;
        ta[3] = PINF; tb[3] = POS2; to[3] = OP_GT;
        out_ready = 1'b1;
        for (int s = 0; s <= 4; s++) begin
            if (s < 4) begin
                set_in(1'b1, ta[s], tb[s], to[s], 8'(s + 1));
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", s, in_ready);
                end
            end else begin
                set_in(1'b0, PZER, PZER, OP_EQ, 8'h00);
            end
            tick();
            if (s == 0) begin
                // One cycle after acceptance: nothing out yet.
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_errors++; $display("FAIL b2b_latency: got out_valid=%b want 0 after 1 cycle", out_valid);
                end
            end else begin
                n_checks++;
                if ({out_valid, out_result, out_unord, out_tag} !== {1'b1, 1'b1, 1'b0, 8'(s)}) begin
                    n_errors++;
                    $display("FAIL b2b_result[%0d]: got v=%b r=%b u=%b tag=%h want v=1 r=1 u=0 tag=%h",
                             s, out_valid, out_result, out_unord, out_tag, 8'(s));
                end
            end
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_directed();
        logic [33:0] ta [8];
        logic [33:0] tb [8];
        logic [2:0]  to [8];
        logic        tr [8];
        ta[0] = PZER; tb[0] = NZER; to[0] = OP_EQ; tr[0] = 1'b1;
        ta[1] = NZER; tb[1] = PZER; to[1] = OP_LT; tr[1] = 1'b0;
        ta[2] = POS1; tb[2] = POS1; to[2] = OP_RS; tr[2] = 1'b0;
        ta[3] = NEG2; tb[3] = NEG1; to[3] = OP_LT; tr[3] = 1'b1;
        ta[4] = NINF; tb[4] = NEG2; to[4] = OP_LT; tr[4] = 1'b1;
        ta[5] = POS2; tb[5] = PINF; to[5] = OP_GT; tr[5] = 1'b0;
        ta[6] = NEG1; tb[6] = POS1; to[6] = OP_EQ; tr[6] = 1'b0;
        ta[7] = PZER; tb[7] = POS1; to[7] = OP_LE; tr[7] = 1'b1;
        out_ready = 1'b1;
        for (int s = 0; s <= 8; s++) begin
            if (s < 8) set_in(1'b1, ta[s], tb[s], to[s], 8'(8'h40 + s));
            else       set_in(1'b0, PZER, PZER, OP_EQ, 8'h00);
            tick();
            if (s >= 1) begin
                n_checks++;
                if ({out_valid, out_result, out_unord, out_tag} !== {1'b1, tr[s-1], 1'b0, 8'(8'h40 + s - 1)}) begin
                    n_errors++;
                    $display("FAIL directed[%0d]: got v=%b r=%b u=%b tag=%h want v=1 r=%b u=0 tag=%h",
                             s - 1, out_valid, out_result, out_unord, out_tag, tr[s-1], 8'(8'h40 + s - 1));
                end
            end
        end
        tick();
    endtask

    task automatic test_nan();
        out_ready = 1'b1;
        set_in(1'b1, QNAN, POS1, OP_GE, 8'h51);
        tick();
        set_in(1'b1, POS1, QNAN, OP_NE, 8'h52);
        tick();
        n_checks++;
        if ({out_valid, out_result, out_unord, out_tag} !== {1'b1, 1'b0, 1'b1, 8'h51}) begin
            n_errors++; $display("FAIL nan_ge: got v=%b r=%b u=%b tag=%h want v=1 r=0 u=1 tag=51",
                                 out_valid, out_result, out_unord, out_tag);
        end
        set_in(1'b0, PZER, PZER, OP_EQ, 8'h00);
        tick();
        n_checks++;
        if ({out_valid, out_result, out_unord, out_tag} !== {1'b1, 1'b1, 1'b1, 8'h52}) begin
            n_errors++; $display("FAIL nan_ne: got v=%b r=%b u=%b tag=%h want v=1 r=1 u=1 tag=52",
                                 out_valid, out_result, out_unord, out_tag);
        end
        tick();
`ifdef FPCMP_NAN_COUNT_EN
        n_checks++;
        if (nan_count !== 16'd2) begin
            n_errors++; $display("FAIL nan_count_two: got %0d want 2", nan_count);
        end
`else
        n_checks++;
        if (nan_count !== 16'd0) begin
            n_errors++; $display("FAIL nan_count_off: got %0d want 0", nan_count);
        end
`endif
    endtask

    task automatic test_stall();
        int idx = 0;
        int got = 0;
        logic exp_res;
        exp_q.delete();
        for (int c = 0; c < 30 && got < 6; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            // Even pairs LT(-1,+1) -> 1, odd pairs GT(-1,+1) -> 0.
            if (idx < 6) set_in(1'b1, NEG1, POS1, (idx % 2 == 0) ? OP_LT : OP_GT, 8'(8'h10 + idx));
            else         set_in(1'b0, PZER, PZER, OP_EQ, 8'h00);
            #1;
            if (c >= 3 && c <= 5) begin
                n_checks++;
                if ({in_ready, out_valid} !== 2'b01) begin
                    n_errors++; $display("FAIL stall_hold[%0d]: got in_ready=%b out_valid=%b want 0/1",
                                         c, in_ready, out_valid);
                end
            end
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL stall_extra: got tag=%h want no output", out_tag);
                end else begin
                    if ({out_result, out_tag} !== exp_q[0]) begin
                        n_errors++; $display("FAIL stall_order: got r=%b tag=%h want r=%b tag=%h",
                                             out_result, out_tag, exp_q[0][8], exp_q[0][7:0]);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_res = (idx % 2 == 0);
                exp_q.push_back({exp_res, 8'(8'h10 + idx)});
                idx++;
            end
            tick();
        end
        out_ready = 1'b1;
        n_checks++;
        if (got != 6 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL stall_count: got %0d delivered (%0d pending) want 6 (0)",
                                 got, exp_q.size());
        end
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b1;
        set_in(1'b1, QNAN, POS1, OP_EQ, 8'h21);
        tick();
        set_in(1'b1, QNAN, QNAN, OP_NE, 8'h22);
        tick();
        set_in(1'b0, PZER, PZER, OP_EQ, 8'h00);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_result, out_unord, out_tag} !== 11'd0) begin
            n_errors++; $display("FAIL rst_inflight_out: got v=%b r=%b u=%b tag=%h want 0",
                                 out_valid, out_result, out_unord, out_tag);
        end
        n_checks++;
        if (nan_count !== 16'd0) begin
            n_errors++; $display("FAIL rst_inflight_count: got %h want 0", nan_count);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++; $display("FAIL rst_stale[%0d]: got out_valid=%b want 0", k, out_valid);
            end
        end
    endtask

    task automatic test_nan_saturate();
        out_ready = 1'b1;
        nan_clr   = 1'b0;
        set_in(1'b1, QNAN, QNAN, OP_EQ, 8'h77);
`ifdef FPCMP_NAN_COUNT_EN
        repeat (65534) tick();
        n_checks++;
        if (nan_count !== 16'hFFFE) begin
            n_errors++; $display("FAIL nan_sat_pre: got %h want fffe", nan_count);
        end
        repeat (3) tick();
        n_checks++;
        if (nan_count !== 16'hFFFF) begin
            n_errors++; $display("FAIL nan_sat: got %h want ffff", nan_count);
        end
`else
        repeat (40) tick();
        n_checks++;
        if (nan_count !== 16'd0) begin
            n_errors++; $display("FAIL nan_sat_off: got %h want 0", nan_count);
        end
`endif
        nan_clr = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL nan_clr_accept: got in_ready=%b want 1", in_ready);
        end
        tick();
        nan_clr = 1'b0;
        set_in(1'b0, PZER, PZER, OP_EQ, 8'h00);
        n_checks++;
        if (nan_count !== 16'd0) begin
            n_errors++; $display("FAIL nan_clr: got %h want 0", nan_count);
        end
        repeat (3) tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        nan_clr   = 1'b0;
        set_in(1'b0, PZER, PZER, OP_EQ, 8'h00);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        test_reset();
        tick();
        test_back_to_back();
        test_directed();
        test_nan();
        test_stall();
        test_reset_inflight();
        test_nan_saturate();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
